// File: rtl/dmem_store.sv
// dmem_store: buffered data-memory store path with an LED register and store-to-load forwarding
module dmem_store #(parameter int DEPTH = 4) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        mem_ready,
  input  logic [31:0] ra,
  output logic [31:0] rd,
  output logic        stall,
  output logic        empty,
  output logic [7:0]  leds
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   ram [64];
  logic [5:0]    fa  [DEPTH];
  logic [31:0]   fd  [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          ram_st, full, push, pop, hit;
  logic [31:0]   hd;
  assign ram_st = we && a != 32'd255 && a != 32'd254;
  assign full   = count == (AW+1)'(DEPTH);
  assign stall  = ram_st && full;
  assign empty  = count == '0;
  assign push   = reset && ram_st && !full;
  assign pop    = reset && !empty && mem_ready;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      leds  <= '0;
    end else begin
      if (we && a == 32'd255) leds <= wd[7:0];
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // entry storage and RAM need no reset: zeroed pointers/count invalidate stale entries
  always_ff @(posedge clk) begin
    if (push) begin
      fa[wp] <= a[7:2];
      fd[wp] <= wd;
    end
    if (pop) ram[fa[rp]] <= fd[rp];
  end
  // scan oldest to newest so the newest matching entry wins
  always_comb begin
    hit = 1'b0;
    hd  = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((AW+1)'(i) < count && fa[rp + AW'(i)] == ra[7:2]) begin
        hit = 1'b1;
        hd  = fd[rp + AW'(i)];
      end
    rd = ra == 32'd255 ? {24'b0, leds} : ra == 32'd254 ? '0 : hit ? hd : ram[ra[7:2]];
  end
endmodule

// File: doc/dmem_store.md
DMEM_STORE -- requirements
Module: dmem_store

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of write-buffer entries (power of two, minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-low (0 = reset at the rising edge of clk).
REQ-004 The block SHALL have port we, input, 1 bit, processor store request.
REQ-005 The block SHALL have port a, input, 32 bits, store address.
REQ-006 The block SHALL have port wd, input, 32 bits, store data.
REQ-007 The block SHALL have port mem_ready, input, 1 bit; high means the RAM write slot is granted this cycle.
REQ-008 The block SHALL have port ra, input, 32 bits, read address.
REQ-009 The block SHALL have port rd, output, 32 bits, read data.
REQ-010 The block SHALL have port stall, output, 1 bit; high means the store is refused and must be held.
REQ-011 The block SHALL have port empty, output, 1 bit; high means no buffered stores.
REQ-012 The block SHALL have port leds, output, 8 bits, the memory-mapped output register.

Function
REQ-013 The address map SHALL be: a == 255 is the LED register; a == 254 is the read-only switch port (stores ignored); every other address is RAM word a[7:2] of a 64 x 32 array.
REQ-014 A store to 255 SHALL load leds <= wd[7:0] at the next edge, bypass the buffer, and never stall.
REQ-015 A store to 254 SHALL have no effect and SHALL never stall.
REQ-016 A RAM store SHALL be pushed as {a[7:2], wd} into a DEPTH-entry FIFO when count < DEPTH.
REQ-017 stall SHALL equal we & RAM-address & (count == DEPTH), combinationally.
REQ-018 A full FIFO SHALL refuse a push even when a pop occurs in the same cycle.
REQ-019 Drain: when count > 0 and mem_ready = 1, the oldest entry SHALL be written to RAM at the edge and popped; at most one pop per cycle.
REQ-020 A simultaneous push and pop (count < DEPTH) SHALL leave count unchanged, with both pointers advancing.
REQ-021 Pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-022 empty SHALL equal (count == 0).
REQ-023 rd SHALL be combinational: if any valid FIFO entry matches ra[7:2], rd = data of the newest matching entry; otherwise rd = RAM[ra[7:2]].
REQ-024 A store pushed this cycle SHALL NOT be visible on rd until the following cycle.
REQ-025 With ra == 255, rd SHALL be {24'b0, leds}; with ra == 254, rd SHALL be 0 (the switch value is muxed outside this block).
REQ-026 RAM latency SHALL be: a pushed entry reaches RAM no earlier than the edge after the push.

Reset
REQ-027 When reset = 0 at an edge: count = 0, read and write pointers = 0, leds = 8'h00.
REQ-028 Reset mid-operation SHALL discard all pending FIFO entries without writing them to RAM.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 During reset, pushes and pops SHALL be suppressed; after reset, empty = 1 and stall = 0.

Verification
REQ-031 Hold mem_ready = 0 and store to 0x00, 0x04, 0x08, 0x0C -> count = 4 and empty = 0; a fifth store to 0x10 -> stall = 1 and is not accepted.
REQ-032 Buffer stores 0x11 then 0x22 to a = 0x08 with mem_ready = 0, and set ra = 0x08 -> rd = 0x22 (forwarding of the newest entry); raise mem_ready for 2 cycles -> empty = 1, and RAM[2] = 0x22.
REQ-033 Store wd = 0x1A5 to a = 255 with the FIFO full -> stall = 0, leds = 0xA5 at the next edge, count unchanged.
REQ-034 Store to a = 254 -> no push, count unchanged, RAM unchanged, stall = 0.
REQ-035 Stream stores every cycle with mem_ready toggling 1,0,1,0 -> RAM order matches store order, and pointers wrap past DEPTH-1 to 0 without loss.
REQ-036 Push 3 entries, then assert reset = 0 for one cycle -> count = 0, leds = 0, the 3 entries are never written, and previously written RAM words are preserved.
